neuron_wb_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares the single neuron_core slave port.
- Master 0 is the Caravel management Wishbone path (wbs_*); master 1 is the on-chip spike sequencer.
- Sits between the user_project_wrapper Wishbone pins and neuron_core.
- Round-robin grant with transaction-level locking; optional per-transaction watchdog timeout.

---
 rtl/neuron_wb_arbiter_if.sv | 18 +
 rtl/neuron_wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_neuron_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_wb_arbiter_if.sv
// Wishbone classic bus bundle shared by the two arbiter masters and the neuron_core slave port.
// master modport: the side that issues cycles; slave modport: the side that acks them.
interface neuron_wb_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic          ack;
  logic [DW-1:0] rdat;

  modport master (output cyc, stb, we, sel, adr, wdat, input ack, rdat);
  modport slave  (input cyc, stb, we, sel, adr, wdat, output ack, rdat);
endinterface

// File: rtl/neuron_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of neuron_core (m0 = Caravel wbs, m1 = spike sequencer).
// Optional watchdog abort enabled by defining NEURON_WB_ARB_TIMEOUT_EN.
module neuron_wb_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  neuron_wb_arbiter_if.slave   m0,
  neuron_wb_arbiter_if.slave   m1,
  neuron_wb_arbiter_if.master  s,
  output logic [1:0]           grant_o,
  output logic                 timeout_o,
  input  logic                 timeout_clr_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TOUT} state_t;

  state_t state;
  logic   last_m1;
  logic   req0, req1;
  logic   gnt_cyc;

  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;
  assign gnt_cyc = (state == GNT1) ? m1.cyc : m0.cyc;
  assign grant_o = {state == GNT1, state == GNT0};

`ifdef NEURON_WB_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
  logic       tout_m1;
`else
  logic unused_cfg;
  assign unused_cfg = timeout_clr_i ^ TIMEOUT_CYCLES[0];
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
`ifdef NEURON_WB_ARB_TIMEOUT_EN
      cnt       <= '0;
      tout_m1   <= 1'b0;
      timeout_o <= 1'b0;
`endif
    end else begin
`ifdef NEURON_WB_ARB_TIMEOUT_EN
      if (timeout_clr_i)
        timeout_o <= 1'b0;
      else if (state == TOUT)
        timeout_o <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last_m1)) begin
            state <= GNT0;
`ifdef NEURON_WB_ARB_TIMEOUT_EN
            cnt <= '0;
`endif
          end else if (req1) begin
            state <= GNT1;
`ifdef NEURON_WB_ARB_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        GNT0, GNT1: begin
          // Ack outranks a same-cycle abort; either way the owner becomes last_served.
          if (s.ack || !gnt_cyc) begin
            state   <= IDLE;
            last_m1 <= (state == GNT1);
          end
`ifdef NEURON_WB_ARB_TIMEOUT_EN
          else begin
            if (cnt != 8'hFF)
              cnt <= cnt + 8'd1;
            if (cnt == CNT_LAST) begin
              state   <= TOUT;
              tout_m1 <= (state == GNT1);
            end
          end
`endif
        end
        TOUT: begin
          state <= IDLE;
`ifdef NEURON_WB_ARB_TIMEOUT_EN
          last_m1 <= tout_m1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    s.sel   = '0;
    s.adr   = '0;
    s.wdat  = '0;
    m0.ack  = 1'b0;
    m0.rdat = '0;
    m1.ack  = 1'b0;
    m1.rdat = '0;
    case (state)
      GNT0: begin
        s.cyc   = m0.cyc;
        s.stb   = m0.stb;
        s.we    = m0.we;
        s.sel   = m0.sel;
        s.adr   = m0.adr;
        s.wdat  = m0.wdat;
        m0.ack  = s.ack;
        m0.rdat = s.rdat;
      end
      GNT1: begin
        s.cyc   = m1.cyc;
        s.stb   = m1.stb;
        s.we    = m1.we;
        s.sel   = m1.sel;
        s.adr   = m1.adr;
        s.wdat  = m1.wdat;
        m1.ack  = s.ack;
        m1.rdat = s.rdat;
      end
`ifdef NEURON_WB_ARB_TIMEOUT_EN
      TOUT: begin
        if (tout_m1) begin
          m1.ack  = 1'b1;
          m1.rdat = DW'(32'hDEAD_BEEF);
        end else begin
          m0.ack  = 1'b1;
          m0.rdat = DW'(32'hDEAD_BEEF);
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_neuron_wb_arbiter.sv
// Directed bench for neuron_wb_arbiter: grant order, locking, abort, watchdog and async reset.
module tb_neuron_wb_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;
  logic       timeout_clr;
  int         tests = 0;
  int         fails = 0;

  neuron_wb_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
  neuron_wb_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
  neuron_wb_arbiter_if #(.AW(32), .DW(32)) s_bus ();

  neuron_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .s             (s_bus),
    .grant_o       (grant),
    .timeout_o     (timeout),
    .timeout_clr_i (timeout_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.sel = '0; m0_bus.adr = '0; m0_bus.wdat = '0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.sel = '0; m1_bus.adr = '0; m1_bus.wdat = '0;
    s_bus.ack = 0; s_bus.rdat = '0; timeout_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    #1;
  endtask

  task automatic req_m0(input logic on);
    m0_bus.cyc = on; m0_bus.stb = on; m0_bus.we = 1'b0; m0_bus.sel = 4'hF; m0_bus.adr = 32'h3000_0004;
  endtask

  task automatic req_m1(input logic on);
    m1_bus.cyc = on; m1_bus.stb = on; m1_bus.we = 1'b1; m1_bus.sel = 4'h3; m1_bus.adr = 32'h3000_0100;
    m1_bus.wdat = 32'h1234_5678;
  endtask

  task automatic test_reset();
    quiet();
    do_reset();
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b exp 00", grant); end
    tests++; if ({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.wdat} !== '0) begin
      fails++; $display("FAIL reset_slave_outs: got cyc=%b adr=%h exp all zero", s_bus.cyc, s_bus.adr); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    s_bus.ack = 1; s_bus.rdat = 32'h0000_0123;
    #1;
    tests++; if ({m0_bus.ack, m1_bus.ack} !== 2'b00 || m0_bus.rdat !== 32'h0 || m1_bus.rdat !== 32'h0) begin
      fails++; $display("FAIL reset_idle_ack: got acks=%b%b dat0=%h exp 00 / 0", m0_bus.ack, m1_bus.ack, m0_bus.rdat); end
    s_bus.ack = 0; s_bus.rdat = '0;
  endtask

  task automatic test_single_master();
    req_m0(1);
    #1;
    tests++; if (s_bus.cyc !== 1'b0) begin fails++; $display("FAIL single_latency: got s_cyc %b exp 0", s_bus.cyc); end
    step();
    tests++; if (s_bus.cyc !== 1'b1 || s_bus.stb !== 1'b1 || s_bus.adr !== 32'h3000_0004 || s_bus.sel !== 4'hF || s_bus.we !== 1'b0) begin
      fails++; $display("FAIL single_slave_mux: got cyc=%b adr=%h sel=%h exp 1 30000004 f", s_bus.cyc, s_bus.adr, s_bus.sel); end
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL single_grant: got %b exp 01", grant); end
    step();
    tests++; if (m0_bus.ack !== 1'b0) begin fails++; $display("FAIL single_early_ack: got %b exp 0", m0_bus.ack); end
    step();
    s_bus.ack = 1; s_bus.rdat = 32'h0000_00A5;
    #1;
    tests++; if (m0_bus.ack !== 1'b1 || m0_bus.rdat !== 32'h0000_00A5) begin
      fails++; $display("FAIL single_ack: got ack=%b dat=%h exp 1 000000a5", m0_bus.ack, m0_bus.rdat); end
    tests++; if (m1_bus.ack !== 1'b0 || m1_bus.rdat !== 32'h0) begin
      fails++; $display("FAIL single_other_master: got ack=%b dat=%h exp 0 0", m1_bus.ack, m1_bus.rdat); end
    step();
    s_bus.ack = 0; s_bus.rdat = '0; req_m0(0);
    tests++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin
      fails++; $display("FAIL single_release: got grant=%b cyc=%b exp 00 0", grant, s_bus.cyc); end
  endtask

  task automatic test_tie_round_robin();
    logic [1:0] exp_grant [3];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
    do_reset();
    req_m0(1); req_m1(1);
    for (int r = 0; r < 3; r++) begin
      step();
      tests++; if (grant !== exp_grant[r]) begin fails++; $display("FAIL tie_round%0d_grant: got %b exp %b", r, grant, exp_grant[r]); end
      step();
      s_bus.ack = 1;
      #1;
      tests++; if ({m1_bus.ack, m0_bus.ack} !== exp_grant[r]) begin
        fails++; $display("FAIL tie_round%0d_ack: got %b%b exp %b", r, m1_bus.ack, m0_bus.ack, exp_grant[r]); end
      step();
      s_bus.ack = 0;
      tests++; if (grant !== 2'b00) begin fails++; $display("FAIL tie_round%0d_idle_gap: got %b exp 00", r, grant); end
    end
    req_m0(0); req_m1(0);
    step();
  endtask

  task automatic test_no_preempt();
    req_m1(1);
    step();
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL nopre_first_grant: got %b exp 10", grant); end
    req_m0(1);
    for (int c = 0; c < 5; c++) begin
      step();
      tests++; if (grant !== 2'b10 || s_bus.adr !== 32'h3000_0100) begin
        fails++; $display("FAIL nopre_hold%0d: got grant=%b adr=%h exp 10 30000100", c, grant, s_bus.adr); end
    end
    s_bus.ack = 1;
    #1;
    tests++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin
      fails++; $display("FAIL nopre_ack_route: got m1=%b m0=%b exp 1 0", m1_bus.ack, m0_bus.ack); end
    step();
    s_bus.ack = 0; req_m1(0);
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL nopre_idle_gap: got %b exp 00", grant); end
    step();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL nopre_m0_after: got %b exp 01", grant); end
    s_bus.ack = 1;
    step();
    s_bus.ack = 0; req_m0(0);
    step();
  endtask

  task automatic test_abort();
    req_m0(1);
    step();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL abort_grant: got %b exp 01", grant); end
    req_m1(1);
    step();
    m0_bus.cyc = 0;
    #1;
    tests++; if (s_bus.cyc !== 1'b0 || grant !== 2'b01) begin
      fails++; $display("FAIL abort_cyc_drop: got cyc=%b grant=%b exp 0 01", s_bus.cyc, grant); end
    step();
    m0_bus.stb = 0;
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL abort_idle: got %b exp 00", grant); end
    step();
    tests++; if (grant !== 2'b10) begin fails++; $display("FAIL abort_m1_next: got %b exp 10", grant); end
    s_bus.ack = 1;
    step();
    s_bus.ack = 0; req_m1(0);
    step();
  endtask

  task automatic test_timeout();
`ifdef NEURON_WB_ARB_TIMEOUT_EN
    req_m1(1);
    for (int c = 0; c < 4; c++) begin
      step();
      tests++; if (grant !== 2'b10 || m1_bus.ack !== 1'b0) begin
        fails++; $display("FAIL tout_wait%0d: got grant=%b ack=%b exp 10 0", c, grant, m1_bus.ack); end
    end
    step();
    tests++; if (m1_bus.ack !== 1'b1 || m1_bus.rdat !== 32'hDEAD_BEEF || s_bus.cyc !== 1'b0 || m0_bus.ack !== 1'b0) begin
      fails++; $display("FAIL tout_abort: got ack=%b dat=%h cyc=%b exp 1 deadbeef 0", m1_bus.ack, m1_bus.rdat, s_bus.cyc); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tout_flag_early: got %b exp 0", timeout); end
    req_m1(0);
    step();
    tests++; if (timeout !== 1'b1 || grant !== 2'b00) begin
      fails++; $display("FAIL tout_flag_set: got flag=%b grant=%b exp 1 00", timeout, grant); end
    s_bus.ack = 1;
    #1;
    tests++; if (m1_bus.ack !== 1'b0) begin fails++; $display("FAIL tout_late_ack: got %b exp 0", m1_bus.ack); end
    step(); step();
    s_bus.ack = 0;
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL tout_sticky: got %b exp 1", timeout); end
    timeout_clr = 1;
    step();
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tout_clear: got %b exp 0", timeout); end
    req_m1(1);
    for (int c = 0; c < 5; c++) step();
    req_m1(0);
    step();
    timeout_clr = 0;
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tout_clear_priority: got %b exp 0", timeout); end
    step();
`else
    req_m1(1);
    for (int c = 0; c < 20; c++) begin
      step();
      tests++; if (grant !== 2'b10 || m1_bus.ack !== 1'b0) begin
        fails++; $display("FAIL tout_off_wait%0d: got grant=%b ack=%b exp 10 0", c, grant, m1_bus.ack); end
    end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL tout_off_flag: got %b exp 0", timeout); end
    req_m1(0);
    step();
    tests++; if (grant !== 2'b00) begin fails++; $display("FAIL tout_off_abort: got %b exp 00", grant); end
`endif
  endtask

  task automatic test_async_reset();
    req_m0(1);
    step();
    tests++; if (grant !== 2'b01 || s_bus.cyc !== 1'b1) begin
      fails++; $display("FAIL areset_pre: got grant=%b cyc=%b exp 01 1", grant, s_bus.cyc); end
    #2 rst = 1;
    #1;
    tests++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin
      fails++; $display("FAIL areset_immediate: got grant=%b cyc=%b exp 00 0", grant, s_bus.cyc); end
    req_m1(1);
    #1 rst = 0;
    step();
    tests++; if (grant !== 2'b01) begin fails++; $display("FAIL areset_tie_m0: got %b exp 01", grant); end
    s_bus.ack = 1;
    step();
    s_bus.ack = 0; req_m0(0); req_m1(0);
    step();
  endtask

  initial begin
    rst = 1;
    quiet();
    test_reset();
    test_single_master();
    test_tie_round_robin();
    test_no_preempt();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
